// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster timing generator.
// Holds the stock 640x480@60 and 800x600 interval sets, the total-length
// derivations and the sync polarity encoding.
package vga_timing_pkg;

    // Sync polarity encoding: the level driven while the sync pulse is active.
    localparam int SYNC_ACTIVE_LOW  = 0;
    localparam int SYNC_ACTIVE_HIGH = 1;

    // 640x480@60, 25.175 MHz pixel clock.
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@60, 40 MHz pixel clock; both syncs are active-high.
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    // Pixels per complete line.
    function automatic int h_total_of(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per complete frame.
    function automatic int v_total_of(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Modulo counter used for both the pixel and the line axis. Counts 0..MAX on
// inc and flags the wrap so the next axis can chain off it. clr forces zero
// regardless of inc so a resynchronise can land the line counter mid-line.
module timing_wrap_counter #(
    parameter int CNT_W = 16,
    parameter int MAX   = 799
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    // Wrap is combinational so the chained counter advances on the same tick.
    assign wrap = inc && (count == MAX_C);

    // Count register: clear wins over increment, wrap folds back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with programmable intervals,
// registered sync/blank levels aligned with the presented counts, line and
// frame strobes, and a completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int HS_POL   = SYNC_ACTIVE_LOW,
    parameter int VS_POL   = SYNC_ACTIVE_LOW,
    parameter int CNT_W    = 16,
    parameter int FRM_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic [FRM_W-1:0] frame_count
);

    localparam int H_TOTAL = h_total_of(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total_of(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Refuse to build a timing that has an empty interval or whose counts
    // cannot be represented in CNT_W bits.
    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_interval
            $error("vga_timing_gen: every timing interval must be at least 1");
        end
        if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CNT_W) ||
            (longint'(V_TOTAL) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON  = (HS_POL != 0);
    localparam logic VS_ON  = (VS_POL != 0);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_OFF = ~VS_ON;

    logic             h_wrap;
    logic             v_wrap;
    logic             v_inc;
    logic             resync;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    assign resync = en && restart;
    assign v_inc  = en && h_wrap;

    timing_wrap_counter #(
        .CNT_W (CNT_W),
        .MAX   (H_TOTAL - 1)
    ) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (en),
        .clr   (resync),
        .count (h_count),
        .wrap  (h_wrap)
    );

    timing_wrap_counter #(
        .CNT_W (CNT_W),
        .MAX   (V_TOTAL - 1)
    ) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (v_inc),
        .clr   (resync),
        .count (v_count),
        .wrap  (v_wrap)
    );

    // Half-open window test on a count value.
    function automatic logic in_span(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

    // Counts the counters will present after this clock; decoding these keeps
    // the registered levels in step with h_count/v_count.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (en) begin
            if (restart) begin
                h_next = '0;
                v_next = '0;
            end else begin
                h_next = h_wrap ? '0 : h_count + 1'b1;
                if (h_wrap) begin
                    v_next = v_wrap ? '0 : v_count + 1'b1;
                end
            end
        end
    end

    // Registered sync/blank levels, strobes and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= en && (h_next == '0);
            frame_start <= en && (h_next == '0) && (v_next == '0);
            if (en) begin
                hsync    <= in_span(h_next, HS_BEG_C, HS_END_C) ? HS_ON : HS_OFF;
                vsync    <= in_span(v_next, VS_BEG_C, VS_END_C) ? VS_ON : VS_OFF;
                video_on <= (h_next < H_ACT_C) && (v_next < V_ACT_C);
                // A resynchronise is not a completed frame.
                if (v_wrap && !restart) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (stock 640x480, a tiny timing
// with mixed polarity and narrow frame counter, and 800x600 active-high)
// share the same stimulus and are compared every cycle against a counting
// model, with literal spot checks pinning the model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic restart = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] d_h, d_v;
    logic        d_hs, d_vs, d_vo, d_ls, d_fs;
    logic [7:0]  d_f;
    logic [7:0]  s_h, s_v;
    logic        s_hs, s_vs, s_vo, s_ls, s_fs;
    logic [2:0]  s_f;
    logic [15:0] w_h, w_v;
    logic        w_hs, w_vs, w_vo, w_ls, w_fs;
    logic [7:0]  w_f;

    vga_timing_gen dut_def (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .h_count(d_h), .v_count(d_v), .hsync(d_hs), .vsync(d_vs),
        .video_on(d_vo), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(SYNC_ACTIVE_HIGH), .VS_POL(SYNC_ACTIVE_LOW),
        .CNT_W(8), .FRM_W(3)
    ) dut_small (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .h_count(s_h), .v_count(s_v), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_vo), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP),
        .H_SYNC(SVGA800_H_SYNC), .H_BP(SVGA800_H_BP),
        .V_ACTIVE(SVGA800_V_ACTIVE), .V_FP(SVGA800_V_FP),
        .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP),
        .HS_POL(SYNC_ACTIVE_HIGH), .VS_POL(SYNC_ACTIVE_HIGH)
    ) dut_svga (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .h_count(w_h), .v_count(w_v), .hsync(w_hs), .vsync(w_vs),
        .video_on(w_vo), .line_start(w_ls), .frame_start(w_fs), .frame_count(w_f)
    );

    // Timing of each configuration, indexed 0=def, 1=small, 2=svga.
    int c_ha[3]  = '{640, 10, 800};
    int c_hf[3]  = '{16, 2, 40};
    int c_hs[3]  = '{96, 3, 128};
    int c_hb[3]  = '{48, 4, 88};
    int c_va[3]  = '{480, 6, 600};
    int c_vf[3]  = '{10, 1, 1};
    int c_vs[3]  = '{2, 2, 4};
    int c_vb[3]  = '{33, 3, 23};
    int c_hp[3]  = '{0, 1, 1};
    int c_vp[3]  = '{0, 0, 1};
    int c_fm[3]  = '{256, 8, 256};

    int mh[3], mv[3], mf[3], mls[3], mfs[3];

    int vec  = 0;
    int miss = 0;

    // Advance the model for configuration k by one clock using current inputs.
    task automatic model_step(input int k);
        int ht, vt;
        ht = c_ha[k] + c_hf[k] + c_hs[k] + c_hb[k];
        vt = c_va[k] + c_vf[k] + c_vs[k] + c_vb[k];
        if (rst) begin
            mh[k] = 0; mv[k] = 0; mf[k] = 0; mls[k] = 0; mfs[k] = 0;
        end else if (en) begin
            if (restart) begin
                mh[k] = 0; mv[k] = 0;
            end else begin
                mh[k] = (mh[k] + 1) % ht;
                if (mh[k] == 0) begin
                    mv[k] = (mv[k] + 1) % vt;
                    if (mv[k] == 0) mf[k] = (mf[k] + 1) % c_fm[k];
                end
            end
            mls[k] = (mh[k] == 0) ? 1 : 0;
            mfs[k] = (mh[k] == 0 && mv[k] == 0) ? 1 : 0;
        end else begin
            mls[k] = 0; mfs[k] = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare one instance's outputs with the model's view of the raster.
    task automatic check_cfg(input int k, input string tag,
                             input int ah, input int av, input int af,
                             input int ahs, input int avs, input int avo,
                             input int als, input int afs);
        int hlo, vlo, ehs, evs, evo;
        hlo = c_ha[k] + c_hf[k];
        vlo = c_va[k] + c_vf[k];
        ehs = (mh[k] >= hlo && mh[k] < hlo + c_hs[k]) ? c_hp[k] : 1 - c_hp[k];
        evs = (mv[k] >= vlo && mv[k] < vlo + c_vs[k]) ? c_vp[k] : 1 - c_vp[k];
        evo = (mh[k] < c_ha[k] && mv[k] < c_va[k]) ? 1 : 0;
        chk({tag, " h_count"}, ah, mh[k]);
        chk({tag, " v_count"}, av, mv[k]);
        chk({tag, " frame_count"}, af, mf[k]);
        chk({tag, " hsync"}, ahs, ehs);
        chk({tag, " vsync"}, avs, evs);
        chk({tag, " video_on"}, avo, evo);
        chk({tag, " line_start"}, als, mls[k]);
        chk({tag, " frame_start"}, afs, mfs[k]);
    endtask

    // Drive one cycle of inputs, clock it, then compare all instances.
    task automatic step(input logic r, input logic e, input logic rs);
        rst = r; en = e; restart = rs;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        check_cfg(0, "def", int'(d_h), int'(d_v), int'(d_f), int'(d_hs),
                  int'(d_vs), int'(d_vo), int'(d_ls), int'(d_fs));
        check_cfg(1, "small", int'(s_h), int'(s_v), int'(s_f), int'(s_hs),
                  int'(s_vs), int'(s_vo), int'(s_ls), int'(s_fs));
        check_cfg(2, "svga", int'(w_h), int'(w_v), int'(w_f), int'(w_hs),
                  int'(w_vs), int'(w_vo), int'(w_ls), int'(w_fs));
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset, including rst winning over en and restart.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("lit reset def h", int'(d_h), 0);
        chk("lit reset def v", int'(d_v), 0);
        chk("lit reset def hsync", int'(d_hs), 1);
        chk("lit reset def vsync", int'(d_vs), 1);
        chk("lit reset def video_on", int'(d_vo), 1);
        chk("lit reset def line_start", int'(d_ls), 0);
        chk("lit reset def frame_start", int'(d_fs), 0);
        chk("lit reset small hsync", int'(s_hs), 0);
        chk("lit reset svga vsync", int'(w_vs), 0);

        // First lines of the stock timing.
        run(640);
        chk("lit def h640", int'(d_h), 640);
        chk("lit def video_on h640", int'(d_vo), 0);
        chk("lit def hsync h640", int'(d_hs), 1);
        run(16);
        chk("lit def hsync h656", int'(d_hs), 0);
        run(95);
        chk("lit def hsync h751", int'(d_hs), 0);
        run(1);
        chk("lit def hsync h752", int'(d_hs), 1);
        run(48);
        chk("lit def h800 wrap", int'(d_h), 0);
        chk("lit def v after line", int'(d_v), 1);
        chk("lit def line_start", int'(d_ls), 1);
        chk("lit def no frame_start", int'(d_fs), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("lit def hold h", int'(d_h), 0);
        chk("lit def strobe width", int'(d_ls), 0);
        run(40);
        chk("lit svga h840", int'(w_h), 840);
        chk("lit svga hsync h840", int'(w_hs), 1);
        run(216);
        chk("lit svga h1056 wrap", int'(w_h), 0);
        chk("lit svga v after line", int'(w_v), 1);

        // Small timing: one frame is 19*12 = 228 ticks.
        step(1'b1, 1'b0, 1'b0);
        run(227);
        chk("lit small h end", int'(s_h), 18);
        chk("lit small v end", int'(s_v), 11);
        chk("lit small frame before", int'(s_f), 0);
        run(1);
        chk("lit small frame after", int'(s_f), 1);
        chk("lit small frame_start", int'(s_fs), 1);
        run(228 * 7 - 1);
        chk("lit small frame 7", int'(s_f), 7);
        run(1);
        chk("lit small frame wrap", int'(s_f), 0);

        // Restart: ignored without en, then loads zero without counting a frame.
        step(1'b1, 1'b0, 1'b0);
        run(228 + 81);
        chk("lit small h pre-restart", int'(s_h), 5);
        chk("lit small v pre-restart", int'(s_v), 4);
        step(1'b0, 1'b0, 1'b1);
        chk("lit small restart idle h", int'(s_h), 5);
        step(1'b0, 1'b1, 1'b1);
        chk("lit small restart h", int'(s_h), 0);
        chk("lit small restart v", int'(s_v), 0);
        chk("lit small restart ls", int'(s_ls), 1);
        chk("lit small restart fs", int'(s_fs), 1);
        chk("lit small restart frame", int'(s_f), 1);
        chk("lit def restart fs", int'(d_fs), 1);

        // Reset while both syncs are active.
        step(1'b1, 1'b0, 1'b0);
        run(146);
        chk("lit small hsync active", int'(s_hs), 1);
        chk("lit small vsync active", int'(s_vs), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("lit small rst h", int'(s_h), 0);
        chk("lit small rst hsync", int'(s_hs), 0);
        chk("lit small rst vsync", int'(s_vs), 1);
        chk("lit small rst ls", int'(s_ls), 0);

        // en one cycle in four.
        for (int i = 0; i < 4000; i++) step(1'b0, (i % 4) == 0, 1'b0);

        // Random en, occasional restart and reset.
        for (int i = 0; i < 16000; i++) begin
            step($urandom_range(0, 2999) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
